switch_debounce_port: RTL and testbench

- Memory-mapped input peripheral for the 16 board switches; the read-side counterpart of the CPU-written seven-segment display port.
- Synchronises and debounces each switch bit, and holds the stable value in a DATA register.
- Records which bits changed since the last acknowledge, as a sticky mask the CPU reads and clears.
- Its read data feeds the read-select mux beside DMEM.

---
 rtl/switch_debounce_port.sv | 127 ++++++++++++
 tb/tb_switch_debounce_port.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_port.sv
// switch_debounce_port
//   Memory-mapped read port for the 16 board switches. Every switch bit is
//   passed through a two-flop synchroniser and then debounced. The accepted
//   value is held in `stable`. A sticky change mask records which bits have
//   toggled since the CPU last read STATUS.
//
//   Register map (addr[1:0] ignored, combinational read):
//     BASE_ADDR     DATA   : {16'b0, stable}
//     BASE_ADDR + 4 STATUS : {change_mask, 15'b0, |change_mask}, read clears mask
//
//   Ports:
//     clk     system clock
//     reset   asynchronous, active-low reset
//     switch  raw switch pins (asynchronous to clk)
//     addr    CPU data address
//     re      CPU read strobe, one cycle per load
//     rdata   read data for addr (0 when not decoded)
//     hit     addr decodes to DATA or STATUS
//     irq     (only with SWITCH_DEBOUNCE_IRQ_EN) registered |change_mask
//
//   Optional feature macro: SWITCH_DEBOUNCE_IRQ_EN
module switch_debounce_port #(
   parameter logic [31:0] BASE_ADDR       = 32'h10020000,
   parameter int unsigned DEBOUNCE_CYCLES = 100000,
   parameter int unsigned CNT_W           = 17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] switch,
   input  logic [31:0] addr,
   input  logic        re,
`ifdef SWITCH_DEBOUNCE_IRQ_EN
   output logic        irq,
`endif
   output logic [31:0] rdata,
   output logic        hit
);

   localparam logic [31:0]      STATUS_ADDR = BASE_ADDR + 32'd4;
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [15:0]      sync1;
   logic [15:0]      sync2;
   logic [15:0]      stable;
   logic [15:0]      change_mask;
   logic [CNT_W-1:0] cnt [16];
   logic [15:0]      accept;
   logic             data_sel;
   logic             status_sel;
   logic             status_clear;
   logic             addr_unused;

   // Byte offset within a word is not decoded.
   assign addr_unused  = ^addr[1:0];
   assign data_sel     = (addr[31:2] == BASE_ADDR[31:2]);
   assign status_sel   = (addr[31:2] == STATUS_ADDR[31:2]);
   assign status_clear = re && status_sel;

   // Bits whose synchronised value has differed from stable for the full
   // debounce window and are accepted on this edge.
   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= switch;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable <= '0;
         for (int unsigned i = 0; i < 16; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         stable <= stable ^ accept;
         for (int unsigned i = 0; i < 16; i++) begin
            if ((sync2[i] == stable[i]) || accept[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // Clear and set on the same edge: the set of a toggling bit wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         change_mask <= '0;
      end else begin
         change_mask <= (status_clear ? '0 : change_mask) | accept;
      end
   end

`ifdef SWITCH_DEBOUNCE_IRQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq <= 1'b0;
      end else begin
         irq <= |change_mask;
      end
   end
`endif

   always_comb begin
      rdata = '0;
      hit   = 1'b0;
      if (data_sel) begin
         rdata = {16'b0, stable};
         hit   = 1'b1;
      end else if (status_sel) begin
         rdata = {change_mask, 15'b0, |change_mask};
         hit   = 1'b1;
      end
   end

endmodule

// File: tb/tb_switch_debounce_port.sv
module tb_switch_debounce_port;

   localparam logic [31:0] BASE = 32'h10020000;
   localparam logic [31:0] STAT = 32'h10020004;

   logic        clk;
   logic        reset;
   logic [15:0] switch;
   logic [31:0] addr;
   logic        re;
   logic [31:0] rdata;
   logic        hit;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
   logic        irq;
`endif

   int pass_cnt;
   int total_cnt;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        hit;
   } vec_t;

   vec_t vecs [11];

   switch_debounce_port #(
      .BASE_ADDR       (BASE),
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .switch (switch),
      .addr   (addr),
      .re     (re),
`ifdef SWITCH_DEBOUNCE_IRQ_EN
      .irq    (irq),
`endif
      .rdata  (rdata),
      .hit    (hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Moves to 1 time unit after the next rising edge.
   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(name, rdata, exp);
   endtask

   task automatic run_table(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         addr = vecs[i].addr;
         #1;
         check($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
         check($sformatf("vec%0d_hit", i), {31'b0, hit}, {31'b0, vecs[i].hit});
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;

      vecs[0]  = '{32'h10020000, 32'h00000000, 1'b1};
      vecs[1]  = '{32'h10020004, 32'h00000000, 1'b1};
      vecs[2]  = '{32'h10020008, 32'h00000000, 1'b0};
      vecs[3]  = '{32'h10020003, 32'h00000000, 1'b1};
      vecs[4]  = '{32'h1001FFFC, 32'h00000000, 1'b0};
      vecs[5]  = '{32'h10020000, 32'h000000A5, 1'b1};
      vecs[6]  = '{32'h10020004, 32'h00A50001, 1'b1};
      vecs[7]  = '{32'h10020002, 32'h000000A5, 1'b1};
      vecs[8]  = '{32'h1002000C, 32'h00000000, 1'b0};
      vecs[9]  = '{32'h10020006, 32'h00000000, 1'b1};
      vecs[10] = '{32'h10020000, 32'h000000A5, 1'b1};

      reset  = 1'b0;
      switch = 16'h0000;
      addr   = BASE;
      re     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      tick(2);

      // Reset state and decode
      run_table(0, 4);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
      check("irq_reset", {31'b0, irq}, 32'd0);
`endif

      // Clean change: accepted on the 6th edge, not the 5th
      switch = 16'h00A5;
      tick(5);
      rd("data_edge5", BASE, 32'h0);
      tick(1);
      run_table(5, 8);

      // Read-to-clear returns the pre-clear value
      addr = STAT;
      re   = 1'b1;
      #1;
      check("status_preclear", rdata, 32'h00A50001);
      tick(1);
      re = 1'b0;
      run_table(9, 10);

      // Glitch on bit 3 shorter than the debounce window
      switch = 16'h00AD;
      tick(3);
      switch = 16'h00A5;
      tick(8);
      rd("glitch_data", BASE, 32'h000000A5);
      rd("glitch_status", STAT, 32'h0);

      // Build mask 0x0100, then accept bit0 on the same edge as a clear
      switch = 16'h01A5;
      tick(6);
      rd("mask_0100", STAT, 32'h01000001);
      switch = 16'h01A4;
      tick(5);
      addr = STAT;
      re   = 1'b1;
      tick(1);
      re = 1'b0;
      rd("set_wins_status", STAT, 32'h00010001);
      rd("set_wins_data", BASE, 32'h000001A4);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
      tick(1);
      check("irq_held_by_set", {31'b0, irq}, 32'd1);
`endif

      // Reset mid-count abandons the count and clears everything
      switch = 16'h81A4;
      tick(3);
      reset = 1'b0;
      #1;
      rd("midreset_data", BASE, 32'h0);
      rd("midreset_status", STAT, 32'h0);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
      check("irq_midreset", {31'b0, irq}, 32'd0);
`endif
      tick(1);
      reset = 1'b1;
      tick(5);
      rd("rearm_edge5", BASE, 32'h0);
      tick(1);
      rd("rearm_data", BASE, 32'h000081A4);
      rd("rearm_status", STAT, 32'h81A40001);
`ifdef SWITCH_DEBOUNCE_IRQ_EN
      check("irq_not_yet", {31'b0, irq}, 32'd0);
      tick(1);
      check("irq_rise", {31'b0, irq}, 32'd1);
      addr = STAT;
      re   = 1'b1;
      tick(1);
      re = 1'b0;
      check("irq_after_clear_edge", {31'b0, irq}, 32'd1);
      tick(1);
      check("irq_fall", {31'b0, irq}, 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
